simmem_mem_responder: RTL and testbench
=======================================

Name: simmem_mem_responder

Overview:
- Deterministic stand-in for the real memory controller, attached to the AXI master side of the simulated memory controller top.
- Accepts read and write addresses and write data.
- Returns write responses and multi-beat read data with a parameterised latency.
- Data payloads follow a fixed pattern so upstream delay and ordering can be checked without a backing RAM.

Parameters:
- WAddrDepth, 4: capacity of the write-address queue.
- RAddrDepth, 4: capacity of the read-address queue.
- WRspDepth, 4: capacity of the write-response queue.
- RLatency, 3: cycles from read-address dequeue to first read beat valid (≥1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- waddr_valid_i  in  1  write-address valid
- waddr_ready_o  out  1  write-address ready
- waddr_i  in  simmem_pkg::waddr_t  write address (id, addr, burst_len)
- wdata_valid_i  in  1  write-data valid
- wdata_ready_o  out  1  write-data ready
- wdata_i  in  simmem_pkg::wdata_t  write-data beat (payload ignored)
- raddr_valid_i  in  1  read-address valid
- raddr_ready_o  out  1  read-address ready
- raddr_i  in  simmem_pkg::raddr_t  read address (id, addr, burst_len)
- rdata_valid_o  out  1  read-data valid
- rdata_ready_i  in  1  read-data ready
- rdata_o  out  simmem_pkg::rdata_t  read beat (id, data, last)
- wrsp_valid_o  out  1  write-response valid
- wrsp_ready_i  in  1  write-response ready
- wrsp_o  out  simmem_pkg::wrsp_t  write response (id)

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset state: all queues empty, beat counters 0, read FSM in IDLE.
- Outputs during reset: every valid_o=0, waddr_ready_o=1, raddr_ready_o=1, wdata_ready_o=0, rdata_o/wrsp_o=0.
- Reset mid-burst: all in-flight state is discarded; nothing is replayed.
- Handshakes: a transfer occurs when valid&&ready are high at a rising edge. Valids never depend combinationally on the same channel's ready. Once an output valid is raised it stays high, with stable payload, until accepted.
- burst_len follows the AXI convention: number of beats = burst_len+1.
- Write-address queue: FIFO of waddr_t. waddr_ready_o = !full. A push and pop in the same cycle is allowed when full; occupancy is unchanged.
- Write-data acceptance: wdata_ready_o = waddr queue non-empty && wrsp queue not full. Beats that arrive before their address are stalled.
- Write beat counting: counter wbeat increments per accepted beat. The last beat is the one where wbeat==head.burst_len.
- Last write beat: in that same edge, pop the waddr head, push wrsp{id=head.id} into the wrsp queue, and clear wbeat. wrsp_valid_o rises the following cycle (1-cycle latency). Response order equals address order.
- Write-response queue: FIFO. wrsp_valid_o = !empty. Simultaneous push and pop are allowed.
- Read-address queue: FIFO. raddr_ready_o = !full.
- Read FSM, IDLE: if the queue is non-empty, pop the head into the current-burst registers, load lat_cnt=RLatency-1, go to WAIT.
- Read FSM, WAIT: decrement lat_cnt. When lat_cnt==0, go to BURST with rbeat=0. First beat is valid exactly RLatency cycles after the pop edge.
- Read FSM, BURST: rdata_valid_o=1. rdata_o.id=cur.id. rdata_o.data=cur.addr+rbeat, zero-extended or truncated to the data width and wrapping modulo 2^width. rdata_o.last=(rbeat==cur.burst_len). Each accepted beat increments rbeat. Accepting the last beat returns to IDLE; there is no bubble-free chaining, so the next pop happens in IDLE one cycle later.
- Read ordering: read bursts never interleave and are returned in address order. Read and write paths are fully independent.
- Counter widths: counters are MaxBurstLenFieldW bits. burst_len=0 yields a single beat with last=1.

Decomposition:
- simmem_pkg holds waddr_t, raddr_t, wdata_t, rdata_t, wrsp_t, MaxBurstLenFieldW, and a new rd_state_e enum {RdIdle, RdWait, RdBurst}.
- One sub-module, simmem_resp_fifo, is used for all three queues. It is a parameterised type and depth FIFO with a full-and-simultaneous-pop pass rule.

Test Plan:
- Read, RLatency=3: raddr{id=2, addr=0x10, burst_len=3} with rdata_ready_i=1 -> first valid 3 cycles after the pop edge; 4 consecutive beats carry data 0x10..0x13 and id 2; last=1 only on 0x13.
- Write ordering: waddr id=1 len=1, then id=5 len=0, then 3 wdata beats, wrsp_ready_i=1 -> wrsp ids 1 then 5, each valid one cycle after its last beat.
- Early write data: wdata_valid_i before any waddr -> wdata_ready_o=0 until the waddr is accepted, then the beat is taken in the first cycle with ready=1.
- Back-pressure: hold wrsp_ready_i=0 and issue 5 single-beat writes -> after 4 responses wdata_ready_o=0. Release ready -> responses drain in order and the 5th write completes.
- Full queue: 4 raddrs queued, raddr_ready_o=0 -> when the head pops, ready returns; a push in the same cycle as a pop at full succeeds; no loss or duplication.
- Reset: assert rst_ni=0 mid-read-burst for one edge -> next cycle rdata_valid_o=0, queues empty, the next burst starts at beat 0.

Source files
------------

// File: rtl/simmem_pkg.sv
// Shared payload types and sizing for the simulated memory responder.
package simmem_pkg;

  localparam int unsigned IdW               = 4;
  localparam int unsigned AddrW             = 32;
  localparam int unsigned DataW             = 32;
  localparam int unsigned MaxBurstLenFieldW = 8;

  typedef struct packed {
    logic [IdW-1:0]               id;
    logic [AddrW-1:0]             addr;
    logic [MaxBurstLenFieldW-1:0] burst_len;
  } waddr_t;

  typedef struct packed {
    logic [IdW-1:0]               id;
    logic [AddrW-1:0]             addr;
    logic [MaxBurstLenFieldW-1:0] burst_len;
  } raddr_t;

  typedef struct packed {
    logic [DataW-1:0] data;
  } wdata_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic             last;
  } rdata_t;

  typedef struct packed {
    logic [IdW-1:0] id;
  } wrsp_t;

  typedef enum logic [1:0] {
    RdIdle,
    RdWait,
    RdBurst
  } rd_state_e;

endpackage

// File: rtl/simmem_mem_responder_if.sv
// Channel bundle between the memory controller's AXI master side and the responder.
interface simmem_mem_responder_if
  import simmem_pkg::*;
;
  logic   waddr_valid_i;
  logic   waddr_ready_o;
  waddr_t waddr_i;
  logic   wdata_valid_i;
  logic   wdata_ready_o;
  wdata_t wdata_i;
  logic   raddr_valid_i;
  logic   raddr_ready_o;
  raddr_t raddr_i;
  logic   rdata_valid_o;
  logic   rdata_ready_i;
  rdata_t rdata_o;
  logic   wrsp_valid_o;
  logic   wrsp_ready_i;
  wrsp_t  wrsp_o;

  modport slave (
    input  waddr_valid_i, waddr_i, wdata_valid_i, wdata_i,
    input  raddr_valid_i, raddr_i, rdata_ready_i, wrsp_ready_i,
    output waddr_ready_o, wdata_ready_o, raddr_ready_o,
    output rdata_valid_o, rdata_o, wrsp_valid_o, wrsp_o
  );

  modport master (
    output waddr_valid_i, waddr_i, wdata_valid_i, wdata_i,
    output raddr_valid_i, raddr_i, rdata_ready_i, wrsp_ready_i,
    input  waddr_ready_o, wdata_ready_o, raddr_ready_o,
    input  rdata_valid_o, rdata_o, wrsp_valid_o, wrsp_o
  );
endinterface

// File: rtl/simmem_resp_fifo.sv
// Typed FIFO; a push is accepted while full when a pop happens in the same cycle.
module simmem_resp_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T              mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/simmem_mem_responder.sv
// Deterministic memory stand-in: queues addresses, acknowledges writes in order and
// returns read bursts whose data is addr+beat after a fixed latency.
module simmem_mem_responder
  import simmem_pkg::*;
#(
  parameter int unsigned WAddrDepth = 4,
  parameter int unsigned RAddrDepth = 4,
  parameter int unsigned WRspDepth  = 4,
  parameter int unsigned RLatency   = 3
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  simmem_mem_responder_if.slave bus
);
  localparam int unsigned LatW = (RLatency > 1) ? $clog2(RLatency) : 1;

  waddr_t waddr_head;
  logic   waddr_full, waddr_empty, waddr_push;
  wrsp_t  wrsp_in;
  logic   wrsp_full, wrsp_empty, wrsp_pop;
  raddr_t raddr_head;
  logic   raddr_full, raddr_empty, raddr_push;

  logic                         wdata_ready_c, wdata_hs, wlast;
  logic [MaxBurstLenFieldW-1:0] wbeat_q, wbeat_d;
  logic                         wdata_unused;

  rd_state_e                    state_q, state_d;
  raddr_t                       cur_q, cur_d;
  logic [LatW-1:0]              lat_q, lat_d;
  logic [MaxBurstLenFieldW-1:0] rbeat_q, rbeat_d;
  logic                         raddr_pop_c, rdata_valid_c;
  rdata_t                       rdata_c;

  // ---------------- write path ----------------
  assign waddr_push    = bus.waddr_valid_i && !waddr_full;
  assign wdata_ready_c = !waddr_empty && !wrsp_full;
  assign wdata_hs      = bus.wdata_valid_i && wdata_ready_c;
  assign wlast         = wdata_hs && (wbeat_q == waddr_head.burst_len);
  assign wrsp_in       = '{id: waddr_head.id};
  assign wrsp_pop      = bus.wrsp_ready_i && !wrsp_empty;
  assign wdata_unused  = ^bus.wdata_i;

  assign bus.waddr_ready_o = !waddr_full;
  assign bus.wdata_ready_o = wdata_ready_c;
  assign bus.wrsp_valid_o  = !wrsp_empty;

  simmem_resp_fifo #(.T(waddr_t), .Depth(WAddrDepth)) u_waddr_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (waddr_push),
    .data_i  (bus.waddr_i),
    .pop_i   (wlast),
    .data_o  (waddr_head),
    .full_o  (waddr_full),
    .empty_o (waddr_empty)
  );

  simmem_resp_fifo #(.T(wrsp_t), .Depth(WRspDepth)) u_wrsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wlast),
    .data_i  (wrsp_in),
    .pop_i   (wrsp_pop),
    .data_o  (bus.wrsp_o),
    .full_o  (wrsp_full),
    .empty_o (wrsp_empty)
  );

  always_comb begin
    wbeat_d = wbeat_q;
    if (wdata_hs) wbeat_d = wlast ? '0 : wbeat_q + MaxBurstLenFieldW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) wbeat_q <= '0;
    else         wbeat_q <= wbeat_d;
  end

  // ---------------- read path ----------------
  assign raddr_push        = bus.raddr_valid_i && !raddr_full;
  assign bus.raddr_ready_o = !raddr_full;
  assign bus.rdata_valid_o = rdata_valid_c;
  assign bus.rdata_o       = rdata_c;

  simmem_resp_fifo #(.T(raddr_t), .Depth(RAddrDepth)) u_raddr_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (raddr_push),
    .data_i  (bus.raddr_i),
    .pop_i   (raddr_pop_c),
    .data_o  (raddr_head),
    .full_o  (raddr_full),
    .empty_o (raddr_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RdIdle;
      cur_q   <= '0;
      lat_q   <= '0;
      rbeat_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      lat_q   <= lat_d;
      rbeat_q <= rbeat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    lat_d   = lat_q;
    rbeat_d = rbeat_q;
    case (state_q)
      RdIdle: begin
        if (!raddr_empty) begin
          cur_d   = raddr_head;
          lat_d   = LatW'(RLatency - 1);
          state_d = RdWait;
        end
      end
      RdWait: begin
        if (lat_q == '0) begin
          state_d = RdBurst;
          rbeat_d = '0;
        end else begin
          lat_d = lat_q - LatW'(1);
        end
      end
      RdBurst: begin
        if (bus.rdata_ready_i) begin
          if (rbeat_q == cur_q.burst_len) begin
            state_d = RdIdle;
            rbeat_d = '0;
          end else begin
            rbeat_d = rbeat_q + MaxBurstLenFieldW'(1);
          end
        end
      end
      default: state_d = RdIdle;
    endcase
  end

  // Beat payload is derived from the registered burst context and beat count.
  always_comb begin
    raddr_pop_c   = 1'b0;
    rdata_valid_c = 1'b0;
    rdata_c       = '0;
    case (state_q)
      RdIdle:  raddr_pop_c = !raddr_empty;
      RdBurst: begin
        rdata_valid_c = 1'b1;
        rdata_c.id    = cur_q.id;
        rdata_c.data  = DataW'(cur_q.addr) + DataW'(rbeat_q);
        rdata_c.last  = (rbeat_q == cur_q.burst_len);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_simmem_mem_responder.sv
// Scoreboard bench for simmem_mem_responder: directed scenarios then randomized traffic.
module tb_simmem_mem_responder;
  import simmem_pkg::*;

  localparam int unsigned RLat  = 3;
  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  simmem_mem_responder_if bus ();

  simmem_mem_responder #(
    .WAddrDepth (Depth),
    .RAddrDepth (Depth),
    .WRspDepth  (Depth),
    .RLatency   (RLat)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  waddr_t         wq[$];
  logic [IdW-1:0] sq[$];
  rdata_t         rq[$];
  int             wbeat_m = 0;
  bit             r_hold = 1'b0, w_hold = 1'b0;
  rdata_t         r_prev;
  wrsp_t          w_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Monitor: compares every cycle and consumes/produces expectations on handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      wq.delete(); sq.delete(); rq.delete();
      wbeat_m = 0; r_hold = 1'b0; w_hold = 1'b0;
    end else begin
      check("waddr_ready", bus.waddr_ready_o, wq.size() < Depth);
      check("wdata_ready", bus.wdata_ready_o, (wq.size() != 0) && (sq.size() < Depth));
      check("wrsp_valid", bus.wrsp_valid_o, sq.size() != 0);
      if (r_hold) begin
        check("rdata_hold_valid", bus.rdata_valid_o, 1'b1);
        check("rdata_hold_payload", bus.rdata_o, r_prev);
      end
      if (w_hold) begin
        check("wrsp_hold_valid", bus.wrsp_valid_o, 1'b1);
        check("wrsp_hold_payload", bus.wrsp_o, w_prev);
      end
      if (bus.wrsp_valid_o && bus.wrsp_ready_i) begin
        check("wrsp_pending", sq.size() != 0, 1'b1);
        if (sq.size() != 0) check("wrsp_id", bus.wrsp_o.id, sq.pop_front());
      end
      if (bus.rdata_valid_o && bus.rdata_ready_i) begin
        check("rdata_pending", rq.size() != 0, 1'b1);
        if (rq.size() != 0) begin
          rdata_t e;
          e = rq.pop_front();
          check("rdata_id", bus.rdata_o.id, e.id);
          check("rdata_data", bus.rdata_o.data, e.data);
          check("rdata_last", bus.rdata_o.last, e.last);
        end
      end
      r_hold = bus.rdata_valid_o && !bus.rdata_ready_i;
      r_prev = bus.rdata_o;
      w_hold = bus.wrsp_valid_o && !bus.wrsp_ready_i;
      w_prev = bus.wrsp_o;
      if (bus.waddr_valid_i && bus.waddr_ready_o) wq.push_back(bus.waddr_i);
      if (bus.wdata_valid_i && bus.wdata_ready_o && wq.size() != 0) begin
        wbeat_m++;
        if (wbeat_m == int'(wq[0].burst_len) + 1) begin
          sq.push_back(wq[0].id);
          void'(wq.pop_front());
          wbeat_m = 0;
        end
      end
      if (bus.raddr_valid_i && bus.raddr_ready_o) begin
        for (int i = 0; i <= int'(bus.raddr_i.burst_len); i++) begin
          rdata_t e;
          e.id   = bus.raddr_i.id;
          e.data = DataW'(bus.raddr_i.addr + AddrW'(i));
          e.last = (i == int'(bus.raddr_i.burst_len));
          rq.push_back(e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns just after the edge at which the channel's valid met ready.
  task automatic hs(input int ch);
    int n = 0;
    bit rdy;
    forever begin
      @(negedge clk);
      case (ch)
        0:       rdy = bus.waddr_ready_o;
        1:       rdy = bus.wdata_ready_o;
        default: rdy = bus.raddr_ready_o;
      endcase
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 300) begin timeout("handshake"); break; end
    end
  endtask

  task automatic send_waddr(input int id, input logic [AddrW-1:0] a, input int len);
    bus.waddr_i = '{id: IdW'(id), addr: a, burst_len: MaxBurstLenFieldW'(len)};
    bus.waddr_valid_i = 1'b1;
    hs(0);
    bus.waddr_valid_i = 1'b0;
  endtask

  task automatic send_beat();
    bus.wdata_i.data = $urandom;
    bus.wdata_valid_i = 1'b1;
    hs(1);
    bus.wdata_valid_i = 1'b0;
  endtask

  task automatic send_raddr(input int id, input logic [AddrW-1:0] a, input int len);
    bus.raddr_i = '{id: IdW'(id), addr: a, burst_len: MaxBurstLenFieldW'(len)};
    bus.raddr_valid_i = 1'b1;
    hs(2);
    bus.raddr_valid_i = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (rq.size() != 0 || sq.size() != 0 || wq.size() != 0 || bus.rdata_valid_o) begin
      step(1);
      n++;
      if (n > limit) begin timeout("drain"); break; end
    end
  endtask

  initial begin
    int n;
    bit rtk, wtk, dtk;
    bus.waddr_valid_i = 1'b0; bus.waddr_i = '0;
    bus.wdata_valid_i = 1'b0; bus.wdata_i = '0;
    bus.raddr_valid_i = 1'b0; bus.raddr_i = '0;
    bus.rdata_ready_i = 1'b0; bus.wrsp_ready_i = 1'b0;
    rst_n = 1'b0;
    step(2);
    check("rst_waddr_ready", bus.waddr_ready_o, 1'b1);
    check("rst_raddr_ready", bus.raddr_ready_o, 1'b1);
    check("rst_wdata_ready", bus.wdata_ready_o, 1'b0);
    check("rst_rdata_valid", bus.rdata_valid_o, 1'b0);
    check("rst_wrsp_valid", bus.wrsp_valid_o, 1'b0);
    check("rst_rdata", bus.rdata_o, '0);
    check("rst_wrsp", bus.wrsp_o, '0);
    rst_n = 1'b1;
    step(1);

    // Read latency: one edge to pop, then RLat edges to the first beat.
    bus.rdata_ready_i = 1'b1;
    send_raddr(2, 32'h10, 3);
    n = 0;
    while (!bus.rdata_valid_o && n < 50) begin step(1); n++; end
    check("read_first_latency", n, RLat + 1);
    n = 0;
    while (bus.rdata_valid_o && n < 50) begin step(1); n++; end
    check("read_consecutive_beats", n, 4);

    // Write ordering and one-cycle response latency.
    bus.wrsp_ready_i = 1'b1;
    send_waddr(1, 32'h100, 1);
    send_waddr(5, 32'h200, 0);
    send_beat();
    send_beat();
    check("wrsp_after_first_last", bus.wrsp_valid_o, 1'b1);
    send_beat();
    check("wrsp_after_second_last", bus.wrsp_valid_o, 1'b1);
    step(1);
    check("wrsp_drained", bus.wrsp_valid_o, 1'b0);

    // Early write data stalls until its address arrives.
    bus.wdata_valid_i = 1'b1;
    step(3);
    check("early_wdata_stalled", bus.wdata_ready_o, 1'b0);
    send_waddr(7, 32'h0, 0);
    check("early_wdata_ready", bus.wdata_ready_o, 1'b1);
    step(1);
    bus.wdata_valid_i = 1'b0;
    check("early_wrsp_valid", bus.wrsp_valid_o, 1'b1);
    step(2);

    // Response back-pressure blocks the fifth write.
    bus.wrsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_waddr(8 + i, 32'h300 + i, 0);
      send_beat();
    end
    send_waddr(12, 32'h400, 0);
    bus.wdata_valid_i = 1'b1;
    step(3);
    check("bp_wdata_stalled", bus.wdata_ready_o, 1'b0);
    check("bp_wrsp_valid", bus.wrsp_valid_o, 1'b1);
    bus.wrsp_ready_i = 1'b1;
    hs(1);
    bus.wdata_valid_i = 1'b0;
    drain(200);

    // Full read-address queue.
    bus.rdata_ready_i = 1'b0;
    send_raddr(3, 32'h40, 1);
    step(2);
    for (int i = 0; i < 4; i++) send_raddr(4 + i, 32'h50 + 16 * i, i);
    check("raddr_full", bus.raddr_ready_o, 1'b0);
    step(5);
    check("raddr_still_full", bus.raddr_ready_o, 1'b0);
    bus.rdata_ready_i = 1'b1;
    n = 0;
    while (!bus.raddr_ready_o && n < 100) begin step(1); n++; end
    check("raddr_ready_returns", bus.raddr_ready_o, 1'b1);
    send_raddr(8, 32'hFFFF_FFFE, 3);
    drain(300);

    // Reset in the middle of a read burst.
    send_raddr(9, 32'h80, 7);
    n = 0;
    while (!bus.rdata_valid_o && n < 50) begin step(1); n++; end
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("mid_rst_rdata_valid", bus.rdata_valid_o, 1'b0);
    check("mid_rst_raddr_ready", bus.raddr_ready_o, 1'b1);
    check("mid_rst_waddr_ready", bus.waddr_ready_o, 1'b1);
    step(1);
    send_raddr(10, 32'h20, 2);
    drain(100);
    check("post_rst_read_done", rq.size(), 0);

    // Randomized traffic on all channels.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rtk = bus.raddr_valid_i && bus.raddr_ready_o;
      wtk = bus.waddr_valid_i && bus.waddr_ready_o;
      dtk = bus.wdata_valid_i && bus.wdata_ready_o;
      @(posedge clk); #1;
      bus.rdata_ready_i = ($urandom_range(0, 3) != 0);
      bus.wrsp_ready_i  = ($urandom_range(0, 3) != 0);
      if (!bus.raddr_valid_i || rtk) begin
        bus.raddr_valid_i = ($urandom_range(0, 3) == 0);
        bus.raddr_i.id = IdW'($urandom);
        bus.raddr_i.addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
        bus.raddr_i.burst_len = MaxBurstLenFieldW'($urandom_range(0, 5));
      end
      if (!bus.waddr_valid_i || wtk) begin
        bus.waddr_valid_i = ($urandom_range(0, 2) == 0);
        bus.waddr_i.id = IdW'($urandom);
        bus.waddr_i.addr = $urandom;
        bus.waddr_i.burst_len = MaxBurstLenFieldW'($urandom_range(0, 4));
      end
      if (!bus.wdata_valid_i || dtk) begin
        bus.wdata_valid_i = ($urandom_range(0, 1) == 0);
        bus.wdata_i.data = $urandom;
      end
    end
    step(1);
    bus.raddr_valid_i = 1'b0;
    bus.waddr_valid_i = 1'b0;
    bus.rdata_ready_i = 1'b1;
    bus.wrsp_ready_i  = 1'b1;
    bus.wdata_valid_i = 1'b1;
    drain(3000);
    bus.wdata_valid_i = 1'b0;
    step(2);
    check("final_rdata_queue", rq.size(), 0);
    check("final_wrsp_queue", sq.size(), 0);
    check("final_rdata_valid", bus.rdata_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
